// File: rtl/qnigma_sipo_pack_pkg.sv
// Shared types for the qnigma serial/parallel framing blocks.
package qnigma_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/qnigma_sipo_pack.sv
// Serial-in, parallel-out frame packer: gathers up to LENGTH words into one
// frame, with valid/ready on both sides, short frames and synchronous flush.
module qnigma_sipo_pack
  import qnigma_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 8,
  parameter int RIGHT  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic [WIDTH-1:0]               ser_i,
  input  logic                           ser_val,
  input  logic                           ser_last,
  output logic                           ser_rdy,
  output logic [LENGTH-1:0][WIDTH-1:0]   par_o,
  output logic [$clog2(LENGTH+1)-1:0]    par_cnt,
  output logic                           par_val,
  input  logic                           par_rdy
);

  localparam int CW = cnt_w(LENGTH);
  localparam int IW = $clog2(LENGTH);

  state_t                         state, state_nx;
  logic [CW-1:0]                  cnt, cnt_nx;
  logic [CW-1:0]                  pcnt_q, pcnt_nx;
  logic [LENGTH-1:0][WIDTH-1:0]   frame_q, frame_nx;
  logic [IW-1:0]                  widx;

  assign ser_rdy = (state == COLLECT) ? 1'b1 : par_rdy;
  assign par_val = (state == HOLD);
  assign par_o   = frame_q;
  assign par_cnt = pcnt_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pcnt_nx  = pcnt_q;
    frame_nx = frame_q;
    if (RIGHT != 0) widx = cnt[IW-1:0];
    else            widx = IW'(LENGTH - 1) - cnt[IW-1:0];

    case (state)
      COLLECT: begin
        if (ser_val) begin
          frame_nx[widx] = ser_i;
          if (cnt == CW'(LENGTH - 1) || ser_last) begin
            state_nx = HOLD;
            pcnt_nx  = cnt + CW'(1);
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (par_rdy) begin
          state_nx = COLLECT;
          frame_nx = '0;
          pcnt_nx  = '0;
          cnt_nx   = '0;
          // cnt is 0 in HOLD, so widx already points at the first-word slot
          if (ser_val) begin
            frame_nx[widx] = ser_i;
            if (ser_last) begin
              state_nx = HOLD;
              pcnt_nx  = CW'(1);
            end else begin
              cnt_nx = CW'(1);
            end
          end
        end
      end
      default: state_nx = COLLECT;
    endcase

    if (clr) begin
      state_nx = COLLECT;
      cnt_nx   = '0;
      pcnt_nx  = '0;
      frame_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= COLLECT;
      cnt     <= '0;
      pcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pcnt_q  <= pcnt_nx;
      frame_q <= frame_nx;
    end
  end

endmodule

// File: tb/tb_qnigma_sipo_pack.sv
// Directed bench for qnigma_sipo_pack: MSW-first and LSW-first instances share stimulus.
module tb_qnigma_sipo_pack;

  logic             clk = 1'b0;
  logic             rst_n, clr, ser_val, ser_last, par_rdy;
  logic [7:0]       ser_i;
  logic             rdy0, rdy1, val0, val1;
  logic [3:0][7:0]  par0, par1;
  logic [2:0]       cnt0, cnt1;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  qnigma_sipo_pack #(.WIDTH(8), .LENGTH(4), .RIGHT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ser_i(ser_i), .ser_val(ser_val),
    .ser_last(ser_last), .ser_rdy(rdy0), .par_o(par0), .par_cnt(cnt0),
    .par_val(val0), .par_rdy(par_rdy));

  qnigma_sipo_pack #(.WIDTH(8), .LENGTH(4), .RIGHT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ser_i(ser_i), .ser_val(ser_val),
    .ser_last(ser_last), .ser_rdy(rdy1), .par_o(par1), .par_cnt(cnt1),
    .par_val(val1), .par_rdy(par_rdy));

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    ser_val = v; ser_i = d; ser_last = l; par_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (val0 !== 1'b0 || val1 !== 1'b0) begin errors++; $display("FAIL reset_val got %b/%b exp 0", val0, val1); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
    checks++; if (par0 !== 32'h0 || par1 !== 32'h0) begin errors++; $display("FAIL reset_par got %h/%h exp 0", par0, par1); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", rdy0); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], i == 3, 1'b0);
      tick();
      if (i < 3) begin
        checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL full_early_val beat %0d got %b exp 0", i, val0); end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (val0 !== 1'b1 || val1 !== 1'b1) begin errors++; $display("FAIL full_val got %b/%b exp 1", val0, val1); end
    checks++; if (par0 !== 32'h11223344) begin errors++; $display("FAIL full_par_msw got %h exp 11223344", par0); end
    checks++; if (par1 !== 32'h44332211) begin errors++; $display("FAIL full_par_lsw got %h exp 44332211", par1); end
    checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", cnt0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [3];
    w[0] = 8'h66; w[1] = 8'h77; w[2] = 8'h88;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      #1;
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_rdy cyc %0d got %b exp 0", i, rdy0); end
      tick();
      checks++; if (par0 !== 32'h11223344 || val0 !== 1'b1 || cnt0 !== 3'd4) begin
        errors++; $display("FAIL bp_hold cyc %0d got %h/%b/%0d exp 11223344/1/4", i, par0, val0, cnt0); end
    end
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b exp 1", rdy0); end
    tick();
    checks++; if (val0 !== 1'b0 || par0 !== 32'h55000000 || par1 !== 32'h00000055) begin
      errors++; $display("FAIL bp_word0 got %b/%h/%h exp 0/55000000/00000055", val0, par0, par1); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w[i], i == 2, 1'b1);
      tick();
    end
    checks++; if (val0 !== 1'b1 || par0 !== 32'h55667788 || cnt0 !== 3'd4) begin
      errors++; $display("FAIL bp_next_frame got %b/%h/%0d exp 1/55667788/4", val0, par0, cnt0); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checks++; if (val0 !== 1'b0 || par0 !== 32'h0 || cnt0 !== 3'd0) begin
      errors++; $display("FAIL bp_consume got %b/%h/%0d exp 0/0/0", val0, par0, cnt0); end
  endtask

  task automatic test_short();
    drive(1'b0, 8'h99, 1'b1, 1'b0);
    tick();
    checks++; if (val0 !== 1'b0 || par0 !== 32'h0) begin errors++; $display("FAIL last_no_val got %b/%h exp 0/0", val0, par0); end
    drive(1'b1, 8'hAA, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hBB, 1'b1, 1'b0); tick();
    checks++; if (val0 !== 1'b1 || cnt0 !== 3'd2) begin errors++; $display("FAIL short_val_cnt got %b/%0d exp 1/2", val0, cnt0); end
    checks++; if (par0 !== 32'hAABB0000) begin errors++; $display("FAIL short_par_msw got %h exp aabb0000", par0); end
    checks++; if (par1 !== 32'h0000BBAA) begin errors++; $display("FAIL short_par_lsw got %h exp 0000bbaa", par1); end
    drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 8'(k), (k % 4) == 0, 1'b1);
      tick();
      checks++; if (val0 !== ((k % 4) == 0)) begin errors++; $display("FAIL b2b_val word %0d got %b exp %b", k, val0, (k % 4) == 0); end
      if ((k % 4) == 0) begin
        exp = {8'(k - 3), 8'(k - 2), 8'(k - 1), 8'(k)};
        checks++; if (par0 !== exp || cnt0 !== 3'd4) begin errors++; $display("FAIL b2b_frame word %0d got %h/%0d exp %h/4", k, par0, cnt0, exp); end
      end
    end
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    tick();
    checks++; if (val0 !== 1'b1 || cnt0 !== 3'd1 || par0 !== 32'h99000000 || par1 !== 32'h00000099) begin
      errors++; $display("FAIL one_word got %b/%0d/%h/%h exp 1/1/99000000/00000099", val0, cnt0, par0, par1); end
    drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
  endtask

  task automatic test_clr_reset();
    drive(1'b1, 8'h21, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    clr = 1'b1;
    drive(1'b1, 8'h23, 1'b1, 1'b0); tick();
    clr = 1'b0;
    checks++; if (val0 !== 1'b0 || par0 !== 32'h0 || cnt0 !== 3'd0) begin
      errors++; $display("FAIL clr got %b/%h/%0d exp 0/0/0", val0, par0, cnt0); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h31 + i), i == 3, 1'b0); tick();
    end
    checks++; if (val0 !== 1'b1 || par0 !== 32'h31323334) begin errors++; $display("FAIL clr_next got %b/%h exp 1/31323334", val0, par0); end
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    rst_n = 1'b1;
    checks++; if (val0 !== 1'b0 || cnt0 !== 3'd0 || par0 !== 32'h0 || par1 !== 32'h0) begin
      errors++; $display("FAIL rst_hold got %b/%0d/%h/%h exp 0/0/0/0", val0, cnt0, par0, par1); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0); tick();
    end
    checks++; if (val0 !== 1'b1 || par0 !== 32'h41424344 || cnt0 !== 3'd4 || par1 !== 32'h44434241) begin
      errors++; $display("FAIL rst_next got %b/%h/%0d/%h exp 1/41424344/4/44434241", val0, par0, cnt0, par1); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short();
    test_back_to_back();
    test_clr_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qnigma_sipo_pack.md
Name: qnigma_sipo_pack

Overview:
- Serial-in, parallel-out frame packer with valid/ready handshakes on both sides.
- Collects up to LENGTH serial words of WIDTH bits and presents them as one parallel frame.
- Sits downstream of the team's PISO shift register on the receive path. Word ordering mirrors the PISO: a frame shifted out by a PISO with the same WIDTH/LENGTH/RIGHT reassembles bit-exact.
- Supports short frames (early ser_last) and a synchronous flush.

Parameters:
- WIDTH, 8, bits per serial word.
- LENGTH, 8, words per full frame (>=2).
- RIGHT, 0: 0 = first word received lands in par_o[LENGTH-1] (MSW-first, matches left-shifting PISO); 1 = first word lands in par_o[0] (matches right-shifting PISO).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous flush: drop partial or held frame.
- ser_i  in  WIDTH  serial data word.
- ser_val  in  1  ser_i valid.
- ser_last  in  1  qualifies ser_i as final word of frame (ignored unless ser_val).
- ser_rdy  out  1  packer can accept ser_i this cycle.
- par_o  out  [LENGTH-1:0][WIDTH-1:0]  packed frame.
- par_cnt  out  $clog2(LENGTH+1)  number of valid words in par_o (1..LENGTH).
- par_val  out  1  frame valid.
- par_rdy  in  1  consumer accepts frame.

Behaviour:
- Reset (rst_n=0 at clk edge): state COLLECT, word counter cnt=0, par_o all zero, par_cnt=0, par_val=0. Reset is valid mid-frame; partial data is discarded.
- Beat accept = ser_val & ser_rdy.
- States:
  - COLLECT: ser_rdy=1, par_val=0.
  - HOLD: par_val=1, ser_rdy=par_rdy. Ready passes through combinationally; this is the only combinational in-to-out path.
- COLLECT, accepted beat:
  - write ser_i to index LENGTH-1-cnt (RIGHT=0) or cnt (RIGHT=1); cnt++.
  - If cnt was LENGTH-1 or ser_last=1: go to HOLD next cycle with par_cnt = cnt+1, cnt=0.
  - Latency: par_val rises the cycle after the final beat is accepted.
- Short frame: unwritten positions stay zero, because the buffer is zeroed at frame start. Valid words are contiguous from the first-word end.
- ser_last on the LENGTH-th word: same as a full frame, no double completion.
- ser_last with ser_val=0: ignored.
- HOLD, par_rdy=1: frame consumed. Buffer and par_cnt are zeroed at the edge and the state returns to COLLECT.
  - If ser_val=1 in the same cycle, that word is accepted as word 0 of the next frame: written into the freshly cleared buffer, cnt=1.
  - If that word also carries ser_last (1-word frame), go straight back to HOLD with par_cnt=1.
- HOLD, par_rdy=0: par_o, par_cnt and par_val held stable; ser_rdy=0.
- par_o/par_cnt change only on the cycle after a handshake or a completion, never while par_val=1 and par_rdy=0.
- clr=1: same effect as reset, except clr loses to rst_n. Overrides any simultaneous accept or consume; the beat offered that cycle is dropped and counts as not accepted even though ser_rdy may read 1.
- Counter width is $clog2(LENGTH+1). No wrap beyond LENGTH: completion is forced at LENGTH words.
- Throughput: one word per cycle. Back-to-back frames with no bubble when par_rdy is held high.

Decomposition:
- Shared package qnigma_pkg: state typedef (COLLECT, HOLD) as a 1-bit enum, and a cnt-width helper function.
- Single module. The write-index generation is small enough to stay inline; no sub-module.

Test Plan:
- WIDTH=8, LENGTH=4, RIGHT=0; send 0x11,0x22,0x33,0x44 with ser_last on 0x44 -> next cycle par_val=1, par_o={0x11,0x22,0x33,0x44} (index 3..0), par_cnt=4.
- Same with RIGHT=1 -> par_o[0]=0x11, par_o[3]=0x44. Loop the PISO (RIGHT=1) into the packer -> output equals the PISO par_i input.
- Short frame: 0xAA,0xBB with ser_last on 0xBB, RIGHT=0 -> par_o={0xAA,0xBB,0x00,0x00}, par_cnt=2.
- Backpressure: hold par_rdy=0 for 5 cycles after a frame -> ser_rdy=0 and par_o stable. Then par_rdy=1 with ser_val=1, ser_i=0x55 -> frame consumed, next frame word 0 = 0x55, no cycle lost.
- Continuous stream: 3 full frames with par_rdy=1 and ser_val=1 every cycle -> par_val pulses every 4 cycles, data correct, no dropped words.
- clr after 2 words, then rst_n=0 while in HOLD -> par_val=0, par_cnt=0, par_o=0. The next 4 words form a clean full frame.
